pulse_period_checker: RTL and testbench

- Downstream consumer of the periodic single-cycle pulse produced by the every-N-cycles pulse generator.
- Measures the interval between successive pulses and checks it against the expected PERIOD within tolerance TOL.
- Reports early and late (missing) pulses, and declares lock after LOCK_COUNT consecutive good intervals.
- Maintains a saturating count of good pulses for status readout.

---
 rtl/pulse_chk_pkg.sv | 14 +
 rtl/pulse_period_checker.sv | 185 ++++++++++++++++++
 tb/tb_pulse_period_checker.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_chk_pkg.sv
// Shared definitions for the pulse period checker.
//   - pc_state_e : FSM state encoding, also driven out on the debug state port
//   - ST_W       : width of the state encoding / state port
package pulse_chk_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } pc_state_e;

endpackage : pulse_chk_pkg

// File: rtl/pulse_period_checker.sv
// Pulse period checker.
// Watches a periodic single-cycle pulse stream, measures the interval between
// accepted pulses and classifies each pulse as good (interval within
// PERIOD +/- TOL) or early. A missing pulse is flagged as late once the gap
// passes PERIOD+TOL. LOCK_COUNT consecutive good intervals enter LOCKED.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en         check enable; low parks the FSM in IDLE, pulse_in ignored
//   clear      synchronous clear, identical effect to reset
//   pulse_in   single-cycle pulse from the upstream generator
//   locked     high while the registered state is LOCKED
//   err_early  one-cycle flag, pulse arrived with interval < PERIOD-TOL
//   err_late   one-cycle flag, no pulse by interval PERIOD+TOL
//   interval   last measured interval, held between pulses
//   good_cnt   saturating count of good pulses
//   state      current FSM state (IDLE=0, SEARCH=1, LOCKED=2)
//
// All outputs are registered and reflect the decision made on the previous
// clk edge.
module pulse_period_checker
    import pulse_chk_pkg::*;
#(
    parameter int PERIOD     = 10,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 3,
    parameter int CNT_W      = 8,
    parameter int PCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic              pulse_in,
    output logic              locked,
    output logic              err_early,
    output logic              err_late,
    output logic [CNT_W-1:0]  interval,
    output logic [PCNT_W-1:0] good_cnt,
    output logic [ST_W-1:0]   state
);

    // Parameter legality, checked at elaboration.
    if (TOL >= PERIOD) begin : g_chk_tol
        $error("pulse_period_checker: TOL must be smaller than PERIOD");
    end
    if ((PERIOD + TOL + 1) >= (2 ** CNT_W)) begin : g_chk_cnt_w
        $error("pulse_period_checker: CNT_W too small for PERIOD+TOL+1");
    end
    if (LOCK_COUNT < 1) begin : g_chk_lock
        $error("pulse_period_checker: LOCK_COUNT must be at least 1");
    end

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] GAP_LO   = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] GAP_LATE = CNT_W'(PERIOD + TOL + 1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);

    pc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  interval_q, interval_d;
    logic [PCNT_W-1:0] good_cnt_q, good_cnt_d;
    logic              err_early_q, err_early_d;
    logic              err_late_q, err_late_d;
    logic              locked_q, locked_d;

    logic [CNT_W-1:0]  gap_inc;
    logic [RUN_W-1:0]  run_inc;
    logic [PCNT_W-1:0] good_inc;

    // Saturating increments.
    assign gap_inc  = (gap_q == '1)      ? gap_q      : gap_q + 1'b1;
    assign run_inc  = (run_q == RUN_LOCK) ? run_q     : run_q + 1'b1;
    assign good_inc = (good_cnt_q == '1) ? good_cnt_q : good_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        run_d       = run_q;
        interval_d  = interval_q;
        good_cnt_d  = good_cnt_q;
        err_early_d = 1'b0;
        err_late_d  = 1'b0;

        if (clear) begin
            state_d    = ST_IDLE;
            gap_d      = '0;
            run_d      = '0;
            interval_d = '0;
            good_cnt_d = '0;
        end else if (!en) begin
            // interval and good_cnt keep their values while disabled.
            state_d = ST_IDLE;
            gap_d   = '0;
            run_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    gap_d = '0;
                    if (pulse_in) begin
                        // First pulse only establishes the reference point.
                        state_d = ST_SEARCH;
                        gap_d   = CNT_W'(1);
                        run_d   = '0;
                    end
                end

                ST_SEARCH, ST_LOCKED: begin
                    if (gap_q == GAP_LATE) begin
                        // Gap just passed the window: report once, then
                        // either drop to IDLE or, if a pulse coincides,
                        // treat it as a fresh first pulse.
                        err_late_d = 1'b1;
                        run_d      = '0;
                        if (pulse_in) begin
                            state_d = ST_SEARCH;
                            gap_d   = CNT_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                            gap_d   = '0;
                        end
                    end else if (pulse_in) begin
                        interval_d = gap_q;
                        gap_d      = CNT_W'(1);
                        if (gap_q < GAP_LO) begin
                            err_early_d = 1'b1;
                            run_d       = '0;
                            state_d     = ST_SEARCH;
                        end else begin
                            // The late check above already caught any gap
                            // beyond PERIOD+TOL, so this pulse is good.
                            good_cnt_d = good_inc;
                            run_d      = run_inc;
                            if (run_inc == RUN_LOCK) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end else begin
                        gap_d = gap_inc;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                    run_d   = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            run_q       <= '0;
            interval_q  <= '0;
            good_cnt_q  <= '0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            run_q       <= run_d;
            interval_q  <= interval_d;
            good_cnt_q  <= good_cnt_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_early = err_early_q;
    assign err_late  = err_late_q;
    assign interval  = interval_q;
    assign good_cnt  = good_cnt_q;
    assign state     = state_q;

endmodule : pulse_period_checker

// File: tb/tb_pulse_period_checker.sv
// Bench for pulse_period_checker. Three instances share one stimulus stream:
//   dut0: defaults (PERIOD=10, TOL=0)
//   dut1: TOL=1
//   dut2: PCNT_W=2 (good_cnt saturates at 3)
// A reference model based on pulse timestamps predicts every output.
module tb_pulse_period_checker;

    localparam int P     = 10;
    localparam int LOCKN = 3;
    localparam int NDUT  = 3;

    logic clk;
    logic rst;
    logic en;
    logic clear;
    logic pulse_in;

    logic       lk0, ee0, el0, lk1, ee1, el1, lk2, ee2, el2;
    logic [7:0] iv0, iv1, iv2;
    logic [15:0] gc0, gc1;
    logic [1:0]  gc2;
    logic [1:0]  st0, st1, st2;

    int n_vec;
    int n_err;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    pulse_period_checker u_dut0 (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .pulse_in(pulse_in),
        .locked(lk0), .err_early(ee0), .err_late(el0), .interval(iv0),
        .good_cnt(gc0), .state(st0)
    );

    pulse_period_checker #(.TOL(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .pulse_in(pulse_in),
        .locked(lk1), .err_early(ee1), .err_late(el1), .interval(iv1),
        .good_cnt(gc1), .state(st1)
    );

    pulse_period_checker #(.PCNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .pulse_in(pulse_in),
        .locked(lk2), .err_early(ee2), .err_late(el2), .interval(iv2),
        .good_cnt(gc2), .state(st2)
    );

    // ---------------- reference model ----------------
    // State: 0 idle, 1 searching, 2 locked. Gap is the number of edges since
    // the last accepted pulse.
    int m_tol  [NDUT] = '{0, 1, 0};
    int m_gmax [NDUT] = '{65535, 65535, 3};
    int m_state[NDUT];
    int m_last [NDUT];
    int m_run  [NDUT];
    int m_intv [NDUT];
    int m_good [NDUT];
    bit m_early[NDUT];
    bit m_late [NDUT];
    int m_cyc;

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_state[k] = 0;
            m_last[k]  = 0;
            m_run[k]   = 0;
            m_intv[k]  = 0;
            m_good[k]  = 0;
            m_early[k] = 1'b0;
            m_late[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        m_cyc++;
        for (int k = 0; k < NDUT; k++) begin
            int g;
            m_early[k] = 1'b0;
            m_late[k]  = 1'b0;
            g = m_cyc - m_last[k];
            if (clear) begin
                m_state[k] = 0;
                m_run[k]   = 0;
                m_intv[k]  = 0;
                m_good[k]  = 0;
            end else if (!en) begin
                m_state[k] = 0;
                m_run[k]   = 0;
            end else if (m_state[k] == 0) begin
                if (pulse_in) begin
                    m_state[k] = 1;
                    m_last[k]  = m_cyc;
                    m_run[k]   = 0;
                end
            end else if (g == P + m_tol[k] + 1) begin
                m_late[k] = 1'b1;
                m_run[k]  = 0;
                if (pulse_in) begin
                    m_state[k] = 1;
                    m_last[k]  = m_cyc;
                end else begin
                    m_state[k] = 0;
                end
            end else if (pulse_in) begin
                m_intv[k] = g;
                m_last[k] = m_cyc;
                if (g < P - m_tol[k]) begin
                    m_early[k] = 1'b1;
                    m_run[k]   = 0;
                    m_state[k] = 1;
                end else begin
                    if (m_good[k] < m_gmax[k]) m_good[k]++;
                    if (m_run[k] < LOCKN) m_run[k]++;
                    if (m_run[k] == LOCKN) m_state[k] = 2;
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Packed view {state, locked, err_early, err_late, interval, good_cnt}.
    function automatic logic [31:0] obs(input int k);
        case (k)
            0:       obs = {3'b0, st0, lk0, ee0, el0, iv0, gc0};
            1:       obs = {3'b0, st1, lk1, ee1, el1, iv1, gc1};
            2:       obs = {3'b0, st2, lk2, ee2, el2, iv2, 14'b0, gc2};
            default: obs = '0;
        endcase
    endfunction

    function automatic logic [31:0] exp_vec(input int k);
        logic lk;
        lk = (m_state[k] == 2);
        exp_vec = {3'b0, 2'(m_state[k]), lk, m_early[k], m_late[k],
                   8'(m_intv[k]), 16'(m_good[k])};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Idle n-1 cycles, then present a pulse for one cycle; returns at the
    // negedge where the decision for that pulse is visible.
    task automatic send_pulse_after(input int n);
        pulse_in = 1'b0;
        for (int i = 0; i < n - 1; i++) tick();
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clear = 1'b0; pulse_in = 1'b0;
        model_reset();
        m_cyc = 0;
        tick();
        tick();
        for (int k = 0; k < NDUT; k++) begin
            n_vec++;
            if (obs(k) !== 32'h0) begin
                n_err++;
                $display("FAIL reset dut%0d: got %h want %h", k, obs(k), 32'h0);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean_stream();
        en = 1'b1;
        for (int p = 0; p < 4; p++) begin
            send_pulse_after((p == 0) ? 3 : P);
            for (int k = 0; k < NDUT; k++) begin
                n_vec++;
                if (obs(k) !== exp_vec(k)) begin
                    n_err++;
                    $display("FAIL clean_p%0d dut%0d: got %h want %h", p, k, obs(k), exp_vec(k));
                end
            end
            if (p == 1) begin
                n_vec++;
                if (iv0 !== 8'd10) begin
                    n_err++;
                    $display("FAIL clean_interval: got %0d want 10", iv0);
                end
            end
        end
        n_vec++;
        if (lk0 !== 1'b1 || gc0 !== 16'd3 || ee0 !== 1'b0 || el0 !== 1'b0) begin
            n_err++;
            $display("FAIL clean_lock: locked=%b good=%0d ee=%b el=%b want 1 3 0 0", lk0, gc0, ee0, el0);
        end
    endtask

    task automatic test_early_locked();
        send_pulse_after(7);
        n_vec++;
        if (ee0 !== 1'b1 || iv0 !== 8'd7 || lk0 !== 1'b0 || st0 !== 2'd1) begin
            n_err++;
            $display("FAIL early_flag: ee=%b iv=%0d lk=%b st=%0d want 1 7 0 1", ee0, iv0, lk0, st0);
        end
        for (int k = 0; k < NDUT; k++) begin
            n_vec++;
            if (obs(k) !== exp_vec(k)) begin
                n_err++;
                $display("FAIL early dut%0d: got %h want %h", k, obs(k), exp_vec(k));
            end
        end
        tick();
        n_vec++;
        if (ee0 !== 1'b0) begin
            n_err++;
            $display("FAIL early_one_cycle: ee=%b want 0", ee0);
        end
        send_pulse_after(P - 1);
        send_pulse_after(P);
        send_pulse_after(P);
        n_vec++;
        if (lk0 !== 1'b1 || gc0 !== 16'd6 || gc2 !== 2'd3) begin
            n_err++;
            $display("FAIL early_relock: lk=%b good=%0d good_sat=%0d want 1 6 3", lk0, gc0, gc2);
        end
        for (int k = 0; k < NDUT; k++) begin
            n_vec++;
            if (obs(k) !== exp_vec(k)) begin
                n_err++;
                $display("FAIL relock dut%0d: got %h want %h", k, obs(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_missing();
        pulse_in = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_vec++;
                if (obs(k) !== exp_vec(k)) begin
                    n_err++;
                    $display("FAIL missing_c%0d dut%0d: got %h want %h", i, k, obs(k), exp_vec(k));
                end
            end
            n_vec++;
            if (el0 !== (i == 11) || el1 !== (i == 12)) begin
                n_err++;
                $display("FAIL late_timing_c%0d: el0=%b el1=%b want %b %b", i, el0, el1, i == 11, i == 12);
            end
            if (i == 11) begin
                n_vec++;
                if (st0 !== 2'd0 || iv0 !== 8'd10) begin
                    n_err++;
                    $display("FAIL late_state: st=%0d iv=%0d want 0 10", st0, iv0);
                end
            end
        end
        send_pulse_after(5);
        n_vec++;
        if (st0 !== 2'd1 || gc0 !== 16'd6 || ee0 !== 1'b0 || el0 !== 1'b0) begin
            n_err++;
            $display("FAIL late_restart: st=%0d good=%0d ee=%b el=%b want 1 6 0 0", st0, gc0, ee0, el0);
        end
    endtask

    task automatic test_tolerance();
        int sp[3] = '{9, 11, 10};
        for (int p = 0; p < 3; p++) begin
            send_pulse_after(sp[p]);
            n_vec++;
            if (iv1 !== 8'(sp[p]) || ee1 !== 1'b0 || el1 !== 1'b0 || lk1 !== (p == 2)) begin
                n_err++;
                $display("FAIL tol_sp%0d: iv=%0d ee=%b el=%b lk=%b want %0d 0 0 %b",
                         sp[p], iv1, ee1, el1, lk1, sp[p], p == 2);
            end
            for (int k = 0; k < NDUT; k++) begin
                n_vec++;
                if (obs(k) !== exp_vec(k)) begin
                    n_err++;
                    $display("FAIL tol_sp%0d dut%0d: got %h want %h", sp[p], k, obs(k), exp_vec(k));
                end
            end
        end
        send_pulse_after(12);
        n_vec++;
        if (el1 !== 1'b1 || st1 !== 2'd1 || iv1 !== 8'd10 || gc1 !== 16'd9 || lk1 !== 1'b0) begin
            n_err++;
            $display("FAIL tol_sp12: el=%b st=%0d iv=%0d good=%0d lk=%b want 1 1 10 9 0",
                     el1, st1, iv1, gc1, lk1);
        end
    endtask

    task automatic test_control();
        for (int p = 0; p < 4; p++) send_pulse_after(P);
        n_vec++;
        if (lk0 !== 1'b1 || lk1 !== 1'b1 || lk2 !== 1'b1) begin
            n_err++;
            $display("FAIL ctrl_prelock: lk=%b%b%b want 111", lk0, lk1, lk2);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            n_vec++;
            if (obs(k) !== 32'h0) begin
                n_err++;
                $display("FAIL clear dut%0d: got %h want %h", k, obs(k), 32'h0);
            end
        end
        send_pulse_after(3);
        send_pulse_after(P);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pulse_in = (i % 3 == 0);
            tick();
            n_vec++;
            if (st0 !== 2'd0 || ee0 !== 1'b0 || el0 !== 1'b0 || gc0 !== 16'd1 || iv0 !== 8'd10) begin
                n_err++;
                $display("FAIL en_low_c%0d: st=%0d ee=%b el=%b good=%0d iv=%0d want 0 0 0 1 10",
                         i, st0, ee0, el0, gc0, iv0);
            end
            for (int k = 0; k < NDUT; k++) begin
                n_vec++;
                if (obs(k) !== exp_vec(k)) begin
                    n_err++;
                    $display("FAIL en_low_c%0d dut%0d: got %h want %h", i, k, obs(k), exp_vec(k));
                end
            end
        end
        pulse_in = 1'b0;
        en = 1'b1;
        tick();
    endtask

    task automatic test_async_reset_and_sat();
        send_pulse_after(3);
        for (int p = 0; p < 3; p++) send_pulse_after(P);
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            n_vec++;
            if (obs(k) !== 32'h0) begin
                n_err++;
                $display("FAIL async_rst dut%0d: got %h want %h", k, obs(k), 32'h0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        send_pulse_after(4);
        n_vec++;
        if (st0 !== 2'd1 || gc0 !== 16'd0 || iv0 !== 8'd0) begin
            n_err++;
            $display("FAIL rst_restart: st=%0d good=%0d iv=%0d want 1 0 0", st0, gc0, iv0);
        end
        for (int p = 0; p < 6; p++) send_pulse_after(P);
        n_vec++;
        if (gc2 !== 2'd3 || gc0 !== 16'd6 || lk2 !== 1'b1) begin
            n_err++;
            $display("FAIL saturate: good_sat=%0d good=%0d lk=%b want 3 6 1", gc2, gc0, lk2);
        end
        for (int k = 0; k < NDUT; k++) begin
            n_vec++;
            if (obs(k) !== exp_vec(k)) begin
                n_err++;
                $display("FAIL saturate dut%0d: got %h want %h", k, obs(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_random();
        int cd;
        int en_off;
        cd = $urandom_range(1, 14);
        en_off = 0;
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 599) == 0);
            clear = ($urandom_range(0, 299) == 0);
            if (en_off > 0) en_off--;
            else if ($urandom_range(0, 199) == 0) en_off = $urandom_range(1, 25);
            en = (en_off == 0);
            cd--;
            if (cd <= 0) begin
                pulse_in = 1'b1;
                if ($urandom_range(0, 3) != 0) cd = $urandom_range(9, 11);
                else                           cd = $urandom_range(1, 14);
            end else begin
                pulse_in = 1'b0;
            end
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_vec++;
                if (obs(k) !== exp_vec(k)) begin
                    n_err++;
                    $display("FAIL random_c%0d dut%0d: got %h want %h", c, k, obs(k), exp_vec(k));
                end
            end
        end
        rst = 1'b0;
        clear = 1'b0;
        pulse_in = 1'b0;
        en = 1'b1;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_clean_stream();
        test_early_locked();
        test_missing();
        test_tolerance();
        test_control();
        test_async_reset_and_sat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pulse_period_checker
